serial_link_training_ctrl: RTL
==============================

SERIAL_LINK_TRAINING_CTRL -- requirements
Module: serial_link_training_ctrl

Interface
REQ-001 SHALL have parameter NumChannels, default serial_link_pkg::NumChannels, number of physical channels.
REQ-002 SHALL have parameter PhyDataWidth, default $bits(serial_link_pkg::phy_data_t), width of one raw word.
REQ-003 SHALL have parameter PatternLen, default 4, training words per channel, range 1..RawModeFifoDepth.
REQ-004 SHALL have parameter TimeoutCycles, default 1024, cycles to wait for each RX word before failing the channel.
REQ-005 SHALL have the following ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start training; sampled only in IDLE.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at end of training.
- ch_ok_o  out  NumChannels  per-channel pass mask, registered.
- raw_mode_en_o  out  1  drives data-link raw mode enable.
- flow_control_fifo_clear_o  out  1  flow-control FIFO flush.
- raw_mode_out_data_fifo_clear_o  out  1  raw TX FIFO flush.
- raw_mode_out_en_o  out  1  raw TX drain enable.
- raw_mode_out_ch_mask_o  out  NumChannels  raw TX channel mask.
- raw_mode_out_data_o  out  PhyDataWidth  raw TX word.
- raw_mode_out_data_valid_o  out  1  raw TX push.
- raw_mode_out_data_fifo_is_full_i  in  1  raw TX FIFO full.
- raw_mode_in_ch_sel_o  out  max(1,clog2(NumChannels))  RX channel select.
- raw_mode_in_data_i  in  PhyDataWidth  RX word of the selected channel.
- raw_mode_in_data_valid_i  in  NumChannels  per-channel RX valid.
- raw_mode_in_data_ready_o  out  1  RX read strobe.

Function
REQ-006 SHALL implement FSM IDLE, CLEAR, SEND, RECV, DONE.
REQ-007 The pattern word k SHALL be (k even ? {PhyDataWidth/2{2'b01}} : {PhyDataWidth/2{2'b10}}) XOR k zero-extended.
REQ-008 IDLE SHALL go to CLEAR the cycle after start_i=1; start_i outside IDLE SHALL be ignored.
REQ-009 CLEAR SHALL last one cycle, pulse both clear outputs, and set the working mask to all ones. It SHALL reset counters k and ch to 0.
REQ-010 raw_mode_en_o SHALL be 1 in CLEAR, SEND and RECV, and 0 in IDLE and DONE.
REQ-011 raw_mode_out_en_o SHALL be 1 in SEND and RECV. raw_mode_out_ch_mask_o SHALL be all ones in SEND and RECV, and 0 elsewhere.
REQ-012 In SEND, raw_mode_out_data_valid_o SHALL equal !raw_mode_out_data_fifo_is_full_i with word k. k SHALL increment on each push.
REQ-013 After push PatternLen-1, SEND SHALL go to RECV with k=0 and ch=0.
REQ-014 In RECV, raw_mode_in_ch_sel_o SHALL equal ch and raw_mode_in_data_ready_o SHALL be 1.
REQ-015 In RECV, a word is accepted when raw_mode_in_data_valid_i[ch]=1. raw_mode_in_data_i SHALL be compared to word k, and a mismatch SHALL clear working mask bit ch. k SHALL then increment.
REQ-016 Acceptance of word PatternLen-1 SHALL advance ch and reset k. Advancing from ch=NumChannels-1 SHALL go to DONE.
REQ-017 DONE SHALL last one cycle: done_o=1, ch_ok_o loaded from the working mask, then return to IDLE.
REQ-018 All outputs not named active in a state SHALL be 0.
REQ-019 Counter widths SHALL be clog2(PatternLen+1) for k and clog2(NumChannels+1) for ch, with no wrap beyond their terminal values.

Reset
REQ-020 Asynchronous reset SHALL force IDLE, k=0, ch=0, timeout=0, working mask 0 and ch_ok_o=0 at any time, including mid-training; all outputs SHALL be 0.

Configuration
REQ-021 With SERIAL_LINK_TRAINING_TIMEOUT_EN defined, the following SHALL apply:
- A timeout counter SHALL count RECV cycles without a valid word on channel ch.
- The counter SHALL reset on each accepted word and on each channel advance.
- On reaching TimeoutCycles-1, the controller SHALL clear mask bit ch and advance the channel per REQ-016.
REQ-022 Without SERIAL_LINK_TRAINING_TIMEOUT_EN, RECV SHALL wait indefinitely, and no timeout logic SHALL be present.

Structure
REQ-023 serial_link_pkg SHALL hold the training_state_e typedef and the pattern-word function.
REQ-024 The timeout SHALL use common_cells counter. No other sub-module is required.

Verification
REQ-025 The bench SHALL use NumChannels=4, PhyDataWidth=8, PatternLen=4 and TimeoutCycles=16.
REQ-026 The bench SHALL cover the following scenarios:
- Good training: start_i pulse; RX returns 55,AB,57,A9 on each channel -> TX pushes 55,AB,57,A9; done_o pulses once; ch_ok_o=4'hF.
- Corrupt channel: channel 2 word 1 is AC -> ch_ok_o=4'hB; the remaining words are still consumed.
- Back-pressure: is_full_i high for 3 cycles in SEND -> no push while full; exactly 4 pushes in order.
- Timeout (macro on): channel 1 never valid -> after 16 idle cycles ch_ok_o bit1=0; channels 0, 2 and 3 pass.
- Reset mid-RECV: rst_ni low at ch=2 -> immediately IDLE, busy_o=0, ch_ok_o=0; a restart then completes normally.
- start_i held high during training -> no restart; exactly one done_o per training.

Source files
------------

// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared types, constants and training pattern for the serial link
package serial_link_pkg;

  localparam int unsigned NumChannels      = 4;
  localparam int unsigned RawModeFifoDepth = 8;
  localparam int unsigned MaxPhyDataWidth  = 64;

  typedef logic [7:0] phy_data_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SEND,
    RECV,
    DONE
  } training_state_e;

  // Alternating 01/10 bit pattern (toggled per word) with the word index folded in,
  // so a stuck lane, a swapped word or a dropped word all show up as a mismatch.
  function automatic logic [MaxPhyDataWidth-1:0] pattern_word(input int unsigned k,
                                                              input int unsigned width);
    logic [MaxPhyDataWidth-1:0] base;
    base = '0;
    for (int unsigned i = 0; i < MaxPhyDataWidth; i++) begin
      if (i < width) begin
        base[i] = ((k % 2) == 0) ? ((i % 2) == 0) : ((i % 2) == 1);
      end
    end
    return base ^ MaxPhyDataWidth'(k);
  endfunction

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - generic up/down counter with clear and load
module counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  // Clear has priority over load, load over counting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (clear_i) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end else if (en_i) begin
      q_o <= down_i ? q_o - Width'(1) : q_o + Width'(1);
    end
  end

endmodule

// File: rtl/serial_link_training_ctrl.sv
// rtl/serial_link_training_ctrl.sv - raw-mode link training sequencer; optional RX timeout via SERIAL_LINK_TRAINING_TIMEOUT_EN
module serial_link_training_ctrl #(
  parameter int unsigned NumChannels   = serial_link_pkg::NumChannels,
  parameter int unsigned PhyDataWidth  = $bits(serial_link_pkg::phy_data_t),
  parameter int unsigned PatternLen    = 4,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned SelW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [NumChannels-1:0]  ch_ok_o,
  output logic                    raw_mode_en_o,
  output logic                    flow_control_fifo_clear_o,
  output logic                    raw_mode_out_data_fifo_clear_o,
  output logic                    raw_mode_out_en_o,
  output logic [NumChannels-1:0]  raw_mode_out_ch_mask_o,
  output logic [PhyDataWidth-1:0] raw_mode_out_data_o,
  output logic                    raw_mode_out_data_valid_o,
  input  logic                    raw_mode_out_data_fifo_is_full_i,
  output logic [SelW-1:0]         raw_mode_in_ch_sel_o,
  input  logic [PhyDataWidth-1:0] raw_mode_in_data_i,
  input  logic [NumChannels-1:0]  raw_mode_in_data_valid_i,
  output logic                    raw_mode_in_data_ready_o
);

  import serial_link_pkg::*;

  localparam int unsigned KW  = $clog2(PatternLen + 1);
  localparam int unsigned ChW = $clog2(NumChannels + 1);

  training_state_e        state_q;
  logic [KW-1:0]          k_q;
  logic [ChW-1:0]         ch_q;
  logic [NumChannels-1:0] mask_q;

  logic [PhyDataWidth-1:0] word_k;
  logic [SelW-1:0]         ch_idx;
  logic                    rx_valid;
  logic                    word_ok;
  logic                    last_k;
  logic                    last_ch;
  logic                    tmo_hit;

  assign word_k   = PhyDataWidth'(pattern_word(32'(k_q), PhyDataWidth));
  assign ch_idx   = ch_q[SelW-1:0];
  assign rx_valid = (state_q == RECV) && raw_mode_in_data_valid_i[ch_idx];
  assign word_ok  = (raw_mode_in_data_i == word_k);
  assign last_k   = (k_q == KW'(PatternLen - 1));
  assign last_ch  = (ch_q == ChW'(NumChannels - 1));

`ifdef SERIAL_LINK_TRAINING_TIMEOUT_EN
  localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  logic [TmoW-1:0] tmo_q;

  // Counts consecutive RECV cycles on the current channel with no valid word.
  assign tmo_hit = (state_q == RECV) && !rx_valid && (tmo_q == TmoW'(TimeoutCycles - 1));

  counter #(
    .Width (TmoW)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i ((state_q != RECV) || rx_valid || tmo_hit),
    .en_i    ((state_q == RECV) && !rx_valid),
    .load_i  (1'b0),
    .down_i  (1'b0),
    .d_i     ('0),
    .q_o     (tmo_q)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  // Training sequencer: flush, push the pattern once, then check every channel in turn.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      ch_q    <= '0;
      mask_q  <= '0;
      ch_ok_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) state_q <= CLEAR;
        end
        CLEAR: begin
          mask_q  <= '1;
          k_q     <= '0;
          ch_q    <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (!raw_mode_out_data_fifo_is_full_i) begin
            if (last_k) begin
              k_q     <= '0;
              ch_q    <= '0;
              state_q <= RECV;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        RECV: begin
          if (rx_valid) begin
            if (!word_ok) mask_q[ch_idx] <= 1'b0;
            if (last_k) begin
              k_q <= '0;
              if (last_ch) state_q <= DONE;
              else         ch_q    <= ch_q + ChW'(1);
            end else begin
              k_q <= k_q + KW'(1);
            end
          end else if (tmo_hit) begin
            mask_q[ch_idx] <= 1'b0;
            k_q            <= '0;
            if (last_ch) state_q <= DONE;
            else         ch_q    <= ch_q + ChW'(1);
          end
        end
        DONE: begin
          ch_ok_o <= mask_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status and link controls decode straight from the state flops.
  assign busy_o                         = (state_q != IDLE);
  assign done_o                         = (state_q == DONE);
  assign raw_mode_en_o                  = (state_q == CLEAR) || (state_q == SEND) || (state_q == RECV);
  assign flow_control_fifo_clear_o      = (state_q == CLEAR);
  assign raw_mode_out_data_fifo_clear_o = (state_q == CLEAR);
  assign raw_mode_out_en_o              = (state_q == SEND) || (state_q == RECV);
  assign raw_mode_out_ch_mask_o         = {NumChannels{raw_mode_out_en_o}};
  assign raw_mode_out_data_o            = (state_q == SEND) ? word_k : '0;
  assign raw_mode_out_data_valid_o      = (state_q == SEND) && !raw_mode_out_data_fifo_is_full_i;
  assign raw_mode_in_ch_sel_o           = (state_q == RECV) ? ch_idx : '0;
  assign raw_mode_in_data_ready_o       = (state_q == RECV);

endmodule
